// File: rtl/hamming_enc_sequencer_if.sv
// ---------------------------------------------------------------------------
// hamming_enc_sequencer_if
//   Bundles every non-clock/reset signal of hamming_enc_sequencer.
//
//   Input stream : in_valid, in_ready, data_in[127:0]
//   Encoder side : enc_enable, enc_data_in[127:0], enc_encoded_data[223:0]
//   Output stream: out_valid, out_ready, out_data[BEAT_W-1:0], out_last
//   Status       : busy, word_count[15:0]
//
//   Modports
//     slave  - the sequencer itself
//     master - the surroundings: data source, external encoder, data sink
// ---------------------------------------------------------------------------
interface hamming_enc_sequencer_if #(
  parameter int BEAT_W = 32
);

  logic              in_valid;
  logic              in_ready;
  logic [127:0]      data_in;

  logic              enc_enable;
  logic [127:0]      enc_data_in;
  logic [223:0]      enc_encoded_data;

  logic              out_valid;
  logic              out_ready;
  logic [BEAT_W-1:0] out_data;
  logic              out_last;

  logic              busy;
  logic [15:0]       word_count;

  modport slave (
    input  in_valid,
    input  data_in,
    input  enc_encoded_data,
    input  out_ready,
    output in_ready,
    output enc_enable,
    output enc_data_in,
    output out_valid,
    output out_data,
    output out_last,
    output busy,
    output word_count
  );

  modport master (
    output in_valid,
    output data_in,
    output enc_encoded_data,
    output out_ready,
    input  in_ready,
    input  enc_enable,
    input  enc_data_in,
    input  out_valid,
    input  out_data,
    input  out_last,
    input  busy,
    input  word_count
  );

endinterface

// File: rtl/hamming_enc_sequencer.sv
// ---------------------------------------------------------------------------
// hamming_enc_sequencer
//   Accepts 128-bit words, presents each one to an external combinational
//   128-to-224 Hamming(7,4) encoder for a single enable cycle, captures the
//   224-bit codeword and streams it out as BEATS = 224/BEAT_W beats, least
//   significant slice first, with valid/ready flow control.
//
//   Ports
//     clk  - sole clock, rising edge
//     rst  - asynchronous, active-high reset
//     bus  - hamming_enc_sequencer_if.slave:
//              in_valid/in_ready/data_in          input word handshake
//              enc_enable/enc_data_in             drive to the encoder
//              enc_encoded_data                   codeword from the encoder
//              out_valid/out_ready/out_data/out_last  beat stream
//              busy                               not in IDLE
//              word_count                         codewords fully sent (wraps)
//
//   Parameter
//     BEAT_W - beat width; one of 8, 16, 32, 56, 112, 224
// ---------------------------------------------------------------------------
module hamming_enc_sequencer #(
  parameter int BEAT_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  hamming_enc_sequencer_if.slave  bus
);

  localparam int BEATS = 224 / BEAT_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next_state;

  logic [127:0]      r_hold;
  logic [223:0]      r_shift;
  logic [CNT_W-1:0]  r_beat;
  logic [CNT_W-1:0]  w_beat_next;
  logic [15:0]       r_word_count;

  logic              r_out_valid;
  logic              r_out_last;
  logic              r_enc_enable;
  logic              r_busy;

  logic              w_accept;
  logic              w_beat_take;
  logic              w_last_take;

  // Next-state logic and handshake qualifiers
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_beat_take  = 1'b0;
    w_last_take  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.in_valid) begin
          w_accept     = 1'b1;
          w_next_state = ST_LOAD;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_LOAD: begin
        // Encoder sees the hold register for exactly this one cycle.
        w_next_state = ST_SEND;
      end
      ST_SEND: begin
        if (bus.out_ready) begin
          w_beat_take = 1'b1;
          if (r_beat == LAST_BEAT) begin
            w_last_take  = 1'b1;
            w_next_state = ST_IDLE;
          end else begin
            w_next_state = ST_SEND;
          end
        end else begin
          w_next_state = ST_SEND;
        end
      end
      default: begin
        // Unreachable encoding: recover to a safe idle state.
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Beat counter next value: cleared on codeword capture, stepped per beat
  always_comb begin
    w_beat_next = r_beat;
    if (r_state == ST_LOAD) begin
      w_beat_next = '0;
    end else if (w_beat_take) begin
      w_beat_next = r_beat + CNT_W'(1);
    end else begin
      w_beat_next = r_beat;
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Input hold register; only an accepted handshake may change it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold <= 128'd0;
    end else if (w_accept) begin
      r_hold <= bus.data_in;
    end
  end

  // Codeword shift register: capture at the end of LOAD, shift per beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift <= 224'd0;
    end else if (r_state == ST_LOAD) begin
      r_shift <= bus.enc_encoded_data;
    end else if (w_beat_take) begin
      r_shift <= r_shift >> BEAT_W;
    end
  end

  // Beat counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_beat <= '0;
    end else begin
      r_beat <= w_beat_next;
    end
  end

  // Completed-codeword counter; wraps naturally from 0xFFFF to 0x0000
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_word_count <= 16'd0;
    end else if (w_last_take) begin
      r_word_count <= r_word_count + 16'd1;
    end
  end

  // Status flags registered from the next state so they line up with r_state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_out_last   <= 1'b0;
      r_enc_enable <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_out_valid  <= (w_next_state == ST_SEND);
      r_out_last   <= (w_next_state == ST_SEND) && (w_beat_next == LAST_BEAT);
      r_enc_enable <= (w_next_state == ST_LOAD);
      r_busy       <= (w_next_state != ST_IDLE);
    end
  end

  // in_ready is gated by rst so it is low during reset and high in the
  // very first cycle after release, without waiting for a clock edge.
  assign bus.in_ready    = (r_state == ST_IDLE) && !rst;
  assign bus.enc_enable  = r_enc_enable;
  assign bus.enc_data_in = r_hold;
  assign bus.out_valid   = r_out_valid;
  assign bus.out_data    = r_shift[BEAT_W-1:0];
  assign bus.out_last    = r_out_last;
  assign bus.busy        = r_busy;
  assign bus.word_count  = r_word_count;

endmodule

// File: tb/tb_hamming_enc_sequencer.sv
module tb_hamming_enc_sequencer;

  localparam int BEAT_W = 32;
  localparam int BEATS  = 224 / BEAT_W;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  hamming_enc_sequencer_if #(.BEAT_W(BEAT_W)) bus ();

  hamming_enc_sequencer #(.BEAT_W(BEAT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference Hamming(7,4) encoder: nibble i -> bits [7i+6:7i] = {p3,p2,p1,d}
  function automatic logic [223:0] ham_enc(input logic [127:0] d);
    logic [223:0] c;
    logic [3:0]   n;
    c = 224'd0;
    for (int i = 0; i < 32; i++) begin
      n = d[4*i +: 4];
      c[7*i +: 7] = {n[1] ^ n[2] ^ n[3], n[0] ^ n[2] ^ n[3], n[0] ^ n[1] ^ n[3], n};
    end
    return c;
  endfunction

  assign bus.enc_encoded_data = ham_enc(bus.enc_data_in);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [223:0] obs, input logic [223:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Send one word; codeword is the expected 224-bit encoding. stall selects
  // the out_ready pattern 1,0,0,1 repeating. stop_after >= 0 ends after that
  // many accepted beats (used for the mid-codeword reset).
  task automatic send_word(input logic [127:0] d, input logic [223:0] codeword,
                           input bit stall, input int stop_after);
    int beat;
    int cyc;
    logic [223:0] exp_beat;
    @(negedge clk);
    chk("in_ready_idle", {223'd0, bus.in_ready}, 224'd1);
    bus.in_valid = 1'b1;
    bus.data_in  = d;
    @(negedge clk);
    // LOAD cycle: keep a conflicting word on the input to prove it is ignored
    bus.data_in  = ~d;
    chk("enc_enable_load", {223'd0, bus.enc_enable}, 224'd1);
    chk("enc_data_in_load", {96'd0, bus.enc_data_in}, {96'd0, d});
    chk("out_valid_load", {223'd0, bus.out_valid}, 224'd0);
    chk("in_ready_load", {223'd0, bus.in_ready}, 224'd0);
    chk("busy_load", {223'd0, bus.busy}, 224'd1);
    @(negedge clk);
    chk("enc_enable_send", {223'd0, bus.enc_enable}, 224'd0);
    beat = 0;
    cyc  = 0;
    while (beat < BEATS && cyc < 100 && (stop_after < 0 || beat < stop_after)) begin
      if (stall) bus.out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      else       bus.out_ready = 1'b1;
      exp_beat = (codeword >> (BEAT_W * beat)) & {192'd0, 32'hFFFF_FFFF};
      chk("out_valid_send", {223'd0, bus.out_valid}, 224'd1);
      chk("out_data", {192'd0, bus.out_data}, exp_beat);
      chk("out_last", {223'd0, bus.out_last}, {223'd0, (beat == BEATS - 1)});
      chk("in_ready_send", {223'd0, bus.in_ready}, 224'd0);
      chk("enc_data_in_hold", {96'd0, bus.enc_data_in}, {96'd0, d});
      if (bus.out_ready) begin
        if (beat == BEATS - 1) bus.in_valid = 1'b0;
        beat++;
      end
      @(negedge clk);
      cyc++;
    end
    chk("beat_budget", (cyc < 100) ? 224'd0 : 224'd1, 224'd0);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b0;
    if (stop_after < 0) begin
      chk("out_valid_after", {223'd0, bus.out_valid}, 224'd0);
      chk("busy_after", {223'd0, bus.busy}, 224'd0);
      chk("in_ready_after", {223'd0, bus.in_ready}, 224'd1);
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_in_ready", {223'd0, bus.in_ready}, 224'd0);
    chk("rst_out_valid", {223'd0, bus.out_valid}, 224'd0);
    chk("rst_out_last", {223'd0, bus.out_last}, 224'd0);
    chk("rst_enc_enable", {223'd0, bus.enc_enable}, 224'd0);
    chk("rst_busy", {223'd0, bus.busy}, 224'd0);
    chk("rst_word_count", {208'd0, bus.word_count}, 224'd0);
    chk("rst_enc_data_in", {96'd0, bus.enc_data_in}, 224'd0);
    chk("rst_out_data", {192'd0, bus.out_data}, 224'd0);
  endtask

  initial begin
    logic [127:0] pat;
    n_vec         = 0;
    n_err         = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.data_in   = 128'd0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs();
    rst = 1'b0;
    #1;
    chk("in_ready_first_cycle", {223'd0, bus.in_ready}, 224'd1);

    // All-zero word: seven zero beats, last on beat 6, count 1
    send_word(128'd0, 224'd0, 1'b0, -1);
    chk("word_count_1", {208'd0, bus.word_count}, 224'd1);

    // Single-bit and all-ones nibble, hand-encoded
    send_word(128'h1, 224'h31, 1'b0, -1);
    send_word(128'hF, 224'h7F, 1'b0, -1);
    chk("word_count_3", {208'd0, bus.word_count}, 224'd3);

    // Mixed pattern with out_ready 1,0,0,1 stalls
    pat = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    send_word(pat, ham_enc(pat), 1'b1, -1);
    chk("word_count_4", {208'd0, bus.word_count}, 224'd4);

    // Reset after beat 3 accepted: abandon the codeword at once
    pat = 128'hDEAD_BEEF_0000_FFFF_A5A5_5A5A_1234_8765;
    send_word(pat, ham_enc(pat), 1'b0, 4);
    rst = 1'b1;
    #1;
    chk_reset_outputs();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("in_ready_after_rst", {223'd0, bus.in_ready}, 224'd1);
    pat = 128'hCAFE_F00D_8421_1248_FFFF_0000_7777_EEEE;
    send_word(pat, ham_enc(pat), 1'b0, -1);
    chk("word_count_after_rst", {208'd0, bus.word_count}, 224'd1);

    // Counter wrap: preset to 0xFFFF while idle, send one word
    @(negedge clk);
    force dut.r_word_count = 16'hFFFF;
    @(negedge clk);
    release dut.r_word_count;
    chk("word_count_preset", {208'd0, bus.word_count}, 224'hFFFF);
    send_word(128'h2, 224'h52, 1'b1, -1);
    chk("word_count_wrap", {208'd0, bus.word_count}, 224'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
